fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Control sequencer for the in-place radix-2, 256-point FFT. On `start` it walks all 8 stages and presents one butterfly per cycle to the butterfly datapath: the two in-place memory addresses, the stage number, and the `k_enable`/`k_clear` strobes that step the downstream twiddle-index counter. It owns stage ordering and pipeline draining between stages, so read-after-write hazards on the shared sample memory cannot occur.

## Interface
- `LOG2N`, 8, log2 of transform size; stages 0..LOG2N-1, N/2 butterflies per stage.
- `PIPE_LAT`, 4, butterfly read-to-writeback latency in cycles; drain length after each stage; 0 allowed.
- `clk`  in  1  clock; all state changes on the rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a transform; sampled only in IDLE.
- `bf_ready`  in  1  datapath accepts the presented butterfly this cycle.
- `bf_valid`  out  1  a butterfly is presented on `addr_a`/`addr_b`.
- `addr_a`  out  LOG2N  upper-leg sample address.
- `addr_b`  out  LOG2N  lower-leg sample address (`addr_a + 2^s`).
- `stage_count_out`  out  4  current stage s.
- `k_enable`  out  1  advance the twiddle-index counter; equals `bf_valid & bf_ready`.
- `k_clear`  out  1  zero the twiddle-index counter.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse when the transform completes.

## Operation
- States: IDLE, CLEAR, ISSUE, DRAIN, DONE.
- IDLE: all outputs 0. `start`=1 -> CLEAR with s=0, b=0.
- CLEAR (1 cycle): `k_clear`=1, `bf_valid`=0 -> ISSUE.
- ISSUE: `bf_valid`=1. The butterfly index b runs 0..N/2-1 (7-bit). With group g = b >> s and k = b & (2^s-1): `addr_a` = g*2^(s+1) + k, `addr_b` = `addr_a` + 2^s. All arithmetic is modulo 2^LOG2N; no carry beyond LOG2N bits.
- On acceptance (`bf_valid & bf_ready`): `k_enable`=1 and b increments. Acceptance at b = N/2-1 -> DRAIN, or -> DONE directly when PIPE_LAT=0 and s = LOG2N-1, or -> CLEAR directly when PIPE_LAT=0 otherwise.
- `bf_ready`=0 holds b and the addresses stable; `k_enable`=0.
- DRAIN: counts PIPE_LAT cycles with `bf_valid`=0. At the end, s = LOG2N-1 -> DONE; otherwise s+1 -> CLEAR.
- DONE (1 cycle): `done`=1, `busy`=1 -> IDLE.
- Twiddle alignment: the downstream counter is cleared in CLEAR and wraps at 2^s. Its registered index output therefore equals the k of the butterfly currently presented in ISSUE. No extra alignment is required here.
- `start` while not in IDLE is ignored.

## Timing
- Reset: state IDLE, s=0, b=0, every output 0. Reset asserted mid-transform aborts immediately with no `done`.
- `start` sampled at edge e0: CLEAR in cycle 1, first butterfly presented in cycle 2.
- With `bf_ready` held at 1, each stage takes 1 + N/2 + PIPE_LAT cycles, which is 133 with the defaults. `done` is high in cycle 8*133+1 = 1065 after e0.
- `addr_a`, `addr_b`, `stage_count_out`, `bf_valid`, `k_clear` and `busy` are registered. `k_enable` is combinational from registered `bf_valid` and input `bf_ready`.
- `stage_count_out` changes only on entry to CLEAR and holds its value through DRAIN. It returns to 0 in IDLE.

## Test plan
- Reset, then idle 5 cycles with `start`=0 -> all outputs 0, `busy`=0.
- `start` pulse with `bf_ready`=1 -> stage 0 emits (0,1),(2,3),...,(254,255); `k_clear` high in cycle 1; `k_enable` high in cycles 2..129.
- Stage 3 at b=9 -> `addr_a`=17, `addr_b`=25. Stage 7 at b=5 -> `addr_a`=5, `addr_b`=133.
- Full run with defaults -> `done` pulse exactly in cycle 1065; 1024 accepted butterflies; each of the 8 stages gives 128 butterflies with every address 0..255 appearing exactly once.
- `bf_ready` deasserted for 3 cycles at stage 2, b=40 -> `addr_a`=80, `addr_b`=84 held constant, `k_enable`=0, `done` delayed by exactly 3 cycles; a second `start` pulse during the run has no effect.
- Reset asserted during stage 4 ISSUE -> outputs 0 immediately. A new `start` then restarts from stage 0 with first pair (0,1).

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 FFT: walks every stage, presents one
// butterfly address pair per accepted cycle, and drains the datapath pipeline between stages.
module fft_stage_sequencer #(
    parameter int LOG2N    = 8,
    parameter int PIPE_LAT = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_start,
    input  logic             i_bf_ready,
    output logic             o_bf_valid,
    output logic [LOG2N-1:0] o_addr_a,
    output logic [LOG2N-1:0] o_addr_b,
    output logic [3:0]       o_stage_count_out,
    output logic             o_k_enable,
    output logic             o_k_clear,
    output logic             o_busy,
    output logic             o_done
);

    localparam int BW = LOG2N - 1;
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [BW-1:0] LAST_B = {BW{1'b1}};
    localparam logic [3:0]    LAST_S = 4'(LOG2N - 1);
    localparam logic [DW-1:0] LAST_D = DW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t          r_state;
    logic [BW-1:0]   r_b;
    logic [3:0]      r_s;
    logic [DW-1:0]   r_drain;
    logic            r_bf_valid;
    logic [LOG2N-1:0] r_addr_a;
    logic [LOG2N-1:0] r_addr_b;
    logic            r_k_clear;
    logic            r_busy;
    logic            r_done;

    // Clearing the low s bits of b and shifting left by one places group g at g*2^(s+1).
    function automatic logic [LOG2N-1:0] f_addr_a(input logic [BW-1:0] b, input logic [3:0] s);
        logic [LOG2N-1:0] w_b;
        logic [LOG2N-1:0] w_lo_mask;
        w_b       = {1'b0, b};
        w_lo_mask = (LOG2N'(1) << s) - LOG2N'(1);
        return ((w_b & ~w_lo_mask) << 1) | (w_b & w_lo_mask);
    endfunction

    logic [BW-1:0]    w_b_inc;
    logic [LOG2N-1:0] w_next_a;
    logic [LOG2N-1:0] w_next_b;
    logic [LOG2N-1:0] w_first_b;
    logic             w_last_stage;

    assign w_b_inc      = r_b + 1'b1;
    assign w_next_a     = f_addr_a(w_b_inc, r_s);
    assign w_next_b     = w_next_a + (LOG2N'(1) << r_s);
    assign w_first_b    = LOG2N'(1) << r_s;
    assign w_last_stage = (r_s == LAST_S);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= S_IDLE;
            r_b        <= '0;
            r_s        <= '0;
            r_drain    <= '0;
            r_bf_valid <= 1'b0;
            r_addr_a   <= '0;
            r_addr_b   <= '0;
            r_k_clear  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state   <= S_CLEAR;
                        r_s       <= '0;
                        r_b       <= '0;
                        r_k_clear <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state    <= S_ISSUE;
                    r_k_clear  <= 1'b0;
                    r_bf_valid <= 1'b1;
                    r_b        <= '0;
                    r_addr_a   <= '0;
                    r_addr_b   <= w_first_b;
                end
                S_ISSUE: begin
                    if (i_bf_ready) begin
                        r_b      <= w_b_inc;
                        r_addr_a <= w_next_a;
                        r_addr_b <= w_next_b;
                        if (r_b == LAST_B) begin
                            r_bf_valid <= 1'b0;
                            r_drain    <= '0;
                            if (PIPE_LAT != 0) begin
                                r_state <= S_DRAIN;
                            end else if (w_last_stage) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state   <= S_CLEAR;
                                r_s       <= r_s + 4'd1;
                                r_k_clear <= 1'b1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain == LAST_D) begin
                        if (w_last_stage) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_CLEAR;
                            r_s       <= r_s + 4'd1;
                            r_k_clear <= 1'b1;
                        end
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_s      <= '0;
                    r_addr_a <= '0;
                    r_addr_b <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_bf_valid        = r_bf_valid;
    assign o_addr_a          = r_addr_a;
    assign o_addr_b          = r_addr_b;
    assign o_stage_count_out = r_s;
    assign o_k_enable        = r_bf_valid & i_bf_ready;
    assign o_k_clear         = r_k_clear;
    assign o_busy            = r_busy;
    assign o_done            = r_done;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: the expected butterfly stream for a whole
// transform is queued at start and a negedge monitor checks every presented/accepted butterfly.
module tb_fft_stage_sequencer;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       i_start = 1'b0;
    logic       i_bf_ready = 1'b0;
    logic       o_bf_valid;
    logic [7:0] o_addr_a;
    logic [7:0] o_addr_b;
    logic [3:0] o_stage_count_out;
    logic       o_k_enable;
    logic       o_k_clear;
    logic       o_busy;
    logic       o_done;

    fft_stage_sequencer #(.LOG2N(8), .PIPE_LAT(4)) dut (
        .clk(clk), .nrst(nrst), .i_start(i_start), .i_bf_ready(i_bf_ready),
        .o_bf_valid(o_bf_valid), .o_addr_a(o_addr_a), .o_addr_b(o_addr_b),
        .o_stage_count_out(o_stage_count_out), .o_k_enable(o_k_enable),
        .o_k_clear(o_k_clear), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {int s; int b; int a; int bb;} item_t;
    item_t q[$];

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    int start_ncyc = 0;
    int run_active = 0;
    int run_done = 0;
    int exp_done = 0;
    int accepted = 0;
    int stage_acc = 0;
    int hits[256];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference stream: pair for butterfly b of stage s from the group/offset decomposition.
    task automatic push_transform();
        item_t it;
        for (int s = 0; s < 8; s++) begin
            for (int b = 0; b < 128; b++) begin
                int g, k;
                g = b / (1 << s);
                k = b % (1 << s);
                it.s = s;
                it.b = b;
                it.a = (g * (2 << s) + k) % 256;
                it.bb = (it.a + (1 << s)) % 256;
                q.push_back(it);
            end
        end
    endtask

    always @(negedge clk) begin
        int cyc;
        ncyc++;
        if (nrst && run_active != 0) begin
            cyc = ncyc - start_ncyc;
            if (cyc == 1) begin
                chk("k_clear_cycle1", int'(o_k_clear), 1);
                chk("valid_cycle1", int'(o_bf_valid), 0);
                chk("busy_cycle1", int'(o_busy), 1);
            end
            if (o_bf_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: butterfly a=%0d b=%0d presented, none expected", o_addr_a, o_addr_b);
                end else begin
                    chk("addr_a", int'(o_addr_a), q[0].a);
                    chk("addr_b", int'(o_addr_b), q[0].bb);
                    chk("stage", int'(o_stage_count_out), q[0].s);
                    chk("k_clear_in_issue", int'(o_k_clear), 0);
                    if (q[0].s == 3 && q[0].b == 9) begin
                        chk("s3b9_addr_a", int'(o_addr_a), 17);
                        chk("s3b9_addr_b", int'(o_addr_b), 25);
                    end
                    if (q[0].s == 7 && q[0].b == 5) begin
                        chk("s7b5_addr_a", int'(o_addr_a), 5);
                        chk("s7b5_addr_b", int'(o_addr_b), 133);
                    end
                    if (q[0].s == 2 && q[0].b == 40 && !i_bf_ready) begin
                        chk("stall_addr_a", int'(o_addr_a), 80);
                        chk("stall_addr_b", int'(o_addr_b), 84);
                        chk("stall_k_enable", int'(o_k_enable), 0);
                    end
                end
            end
            if (o_k_enable) begin
                chk("k_enable_needs_valid", int'(o_bf_valid), 1);
                if (q.size() != 0) begin
                    accepted++;
                    if (accepted == 1) chk("first_accept_cycle", cyc, 2);
                    hits[o_addr_a]++;
                    hits[o_addr_b]++;
                    void'(q.pop_front());
                    stage_acc++;
                    if (stage_acc == 128) begin
                        int bad = 0;
                        for (int i = 0; i < 256; i++) begin
                            if (hits[i] != 1) bad++;
                            hits[i] = 0;
                        end
                        chk("stage_addr_cover", bad, 0);
                        stage_acc = 0;
                    end
                end
            end
            if (o_done) begin
                if (exp_done > 0) chk("done_cycle", cyc, exp_done);
                chk("accepted_total", accepted, 1024);
                chk("sb_left", q.size(), 0);
                chk("busy_at_done", int'(o_busy), 1);
                run_done = 1;
            end
        end
    end

    task automatic idle_check(input string tag);
        chk({tag, "_bf_valid"}, int'(o_bf_valid), 0);
        chk({tag, "_addr_a"}, int'(o_addr_a), 0);
        chk({tag, "_addr_b"}, int'(o_addr_b), 0);
        chk({tag, "_stage"}, int'(o_stage_count_out), 0);
        chk({tag, "_k_enable"}, int'(o_k_enable), 0);
        chk({tag, "_k_clear"}, int'(o_k_clear), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_done"}, int'(o_done), 0);
    endtask

    // mode 0: ready held high; 1: 3-cycle stall at stage 2 b=40 plus a stray start;
    // 2: random ready; 3: abort by reset during stage 4 issue.
    task automatic run(input int mode);
        int c;
        q.delete();
        push_transform();
        accepted = 0;
        stage_acc = 0;
        for (int i = 0; i < 256; i++) hits[i] = 0;
        run_done = 0;
        exp_done = (mode == 0) ? 1065 : (mode == 1) ? 1068 : 0;
        @(posedge clk);
        #1;
        start_ncyc = ncyc + 1;
        i_start = 1'b1;
        i_bf_ready = 1'b1;
        run_active = 1;
        c = 0;
        while (run_done == 0 && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
            i_start = (mode == 1 && c == 600);
            case (mode)
                1: i_bf_ready = !(c >= 308 && c <= 310);
                2: i_bf_ready = ($urandom_range(0, 3) != 0);
                default: i_bf_ready = 1'b1;
            endcase
            if (mode == 3 && o_stage_count_out == 4'd4 && o_bf_valid) begin
                #2;
                nrst = 1'b0;
                #1;
                run_active = 0;
                idle_check("abort");
                q.delete();
                break;
            end
        end
        run_active = 0;
        i_start = 1'b0;
        if (mode == 3) begin
            chk("abort_no_done", run_done, 0);
        end else begin
            chk("run_completed", run_done, 1);
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            idle_check("post_run");
        end
    endtask

    initial begin
        #22;
        nrst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            idle_check("reset_idle");
        end
        run(0);
        run(1);
        run(2);
        run(3);
        repeat (3) @(posedge clk);
        #1;
        idle_check("in_reset");
        nrst = 1'b1;
        @(posedge clk);
        #1;
        run(0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
